// File: rtl/ro_capture_pkg.sv
// Shared types and helpers for the readout capture block.
// Build option: RO_CAPTURE_TIMESTAMP_EN prepends a free-running timestamp to each record.
package ro_capture_pkg;

  // Channel index width: clog2 of the core count, never below one bit.
  function automatic int ch_w(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

`ifdef RO_CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Record width for a given core count and timestamp width.
  function automatic int rec_w(input int n_ch, input int ts_w);
    return ch_w(n_ch) + 1 + (TS_EN ? ts_w : 0);
  endfunction

  localparam int N_CH_DEF  = 8;
  localparam int TS_W_DEF  = 16;
  localparam int CH_W_DEF  = ch_w(N_CH_DEF);
  localparam int REC_W_DEF = rec_w(N_CH_DEF, TS_W_DEF);

  // Field offsets inside a record (LSB first: pol, ch, ts).
  localparam int POL_LSB = 0;
  localparam int CH_LSB  = 1;
  localparam int TS_LSB  = CH_LSB + CH_W_DEF;

  typedef struct packed {
`ifdef RO_CAPTURE_TIMESTAMP_EN
    logic [TS_W_DEF-1:0] ts;
`endif
    logic [CH_W_DEF-1:0] ch;
    logic                pol;
  } rec_t;

endpackage

// File: rtl/ro_capture_if.sv
// Valid/ready record stream from the capture block to the host-side consumer.
interface ro_capture_if #(
  parameter int REC_W = 4
);
  logic             m_valid;
  logic             m_ready;
  logic [REC_W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/ro_capture_fifo.sv
// Record FIFO with a registered head: a record pushed at edge T is presented
// from T+1. Pointers carry one extra bit to tell full from empty.
module ro_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rdata_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ;
  logic [AW-1:0]    rd_nxt_idx;
  logic [WIDTH-1:0] head_q;
  logic             empty, one_left, fire_pop, fire_push;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occ        = wr_ptr_q - rd_ptr_q;
  assign one_left   = (occ == (AW+1)'(1));
  assign rd_nxt_idx = rd_ptr_q[AW-1:0] + AW'(1);
  assign fire_pop   = pop_i && !empty;
  assign fire_push  = push_i && (!full_o || fire_pop);
  assign valid_o    = !empty;
  assign rdata_o    = head_q;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (fire_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fire_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (fire_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Head register: load the incoming record when it becomes the head,
  // otherwise advance to the next stored entry on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else if (fire_push && (empty || (fire_pop && one_left))) begin
      head_q <= wdata_i;
    end else if (fire_pop && !one_left) begin
      head_q <= mem_q[rd_nxt_idx];
    end
  end

endmodule

// File: rtl/ro_capture.sv
// Readout bus capture: decodes the slot owner from single-bit gray transitions,
// samples the shared event/polarity lines in that slot, and queues records.
// Build option: RO_CAPTURE_TIMESTAMP_EN adds a TS_W-bit timestamp per record.
module ro_capture
  import ro_capture_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8,
  parameter int TS_W   = TS_W_DEF
) (
  input  logic              clk_master,
  input  logic              rstb,
  input  logic [N_CH-1:0]   gray,
  input  logic              rd_eve,
  input  logic              rd_pol,
  ro_capture_if.master      m,
  input  logic              clr,
  output logic              ovf,
  output logic              gray_err,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int CH_W  = ch_w(N_CH);
  localparam int REC_W = rec_w(N_CH, TS_W);

  logic [N_CH-1:0]   gray_q;
  logic [N_CH-1:0]   diff;
  logic              slot_ok, multi_hot;
  logic [CH_W-1:0]   slot_ch;
  logic              push, drop;
  logic [REC_W-1:0]  rec_d;
  logic              fifo_full, fifo_valid;
  logic [REC_W-1:0]  fifo_data;
  logic              ovf_q, gray_err_q;
  logic [DROP_W-1:0] drop_cnt_q;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  assign diff      = gray ^ gray_q;
  assign slot_ok   = (diff != '0) && ((diff & (diff - N_CH'(1))) == '0);
  assign multi_hot = (diff != '0) && !slot_ok;

  // One-hot to channel index for the slot owner.
  always_comb begin
    slot_ch = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (diff[k]) slot_ch = CH_W'(k);
    end
  end

  // Bus lines only matter inside a valid slot, so undriven values stay out of state.
  assign push = slot_ok && rd_eve;
  assign drop = push && fifo_full && !(fifo_valid && m.m_ready);

`ifdef RO_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  assign rec_d = {ts_q, slot_ch, rd_pol};
`else
  assign rec_d = {slot_ch, rd_pol};
`endif

  // Previous gray value for transition detection.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) gray_q <= '0;
    else       gray_q <= gray;
  end

  // Sticky flags and drop counter; a new event in the clearing edge wins.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      ovf_q      <= 1'b0;
      gray_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (multi_hot)  gray_err_q <= 1'b1;
      else if (clr)   gray_err_q <= 1'b0;

      if (drop)       ovf_q <= 1'b1;
      else if (clr)   ovf_q <= 1'b0;

      if (drop)       drop_cnt_q <= clr ? DROP_W'(1) : sat_inc(drop_cnt_q);
      else if (clr)   drop_cnt_q <= '0;
    end
  end

  ro_capture_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk_master),
    .rst_n   (rstb),
    .push_i  (push),
    .wdata_i (rec_d),
    .full_o  (fifo_full),
    .pop_i   (m.m_ready),
    .valid_o (fifo_valid),
    .rdata_o (fifo_data)
  );

  assign m.m_valid = fifo_valid;
  assign m.m_data  = fifo_data;
  assign ovf       = ovf_q;
  assign gray_err  = gray_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
